// File: rtl/base_pkg.sv
// rtl/base_pkg.sv - shared APB4 bus structs used across the bridge blocks
package base_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef struct packed {
    logic [APB_ADDR_W-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [APB_DATA_W-1:0]   pwdata;
    logic [APB_DATA_W/8-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;
  } apb_resp_t;

endpackage

// File: rtl/simple_if_pkg.sv
// rtl/simple_if_pkg.sv - state encoding, defaults and response type for simple_if_to_apb
package simple_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } simple_if_to_apb_state_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 256;

  typedef struct packed {
    logic [base_pkg::APB_DATA_W-1:0] rdata;
    logic                            err;
  } simple_if_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase wait counter; expired_o flags the LIMIT-th stalled cycle
module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!arst_ni || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Combinational so the abort lands on the same edge as the LIMIT-th stall.
  assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/simple_if_to_apb.sv
// rtl/simple_if_to_apb.sv - simple valid/ready request port to APB4 initiator; SIMPLE_IF_TO_APB_TIMEOUT_EN adds an ACCESS timeout
module simple_if_to_apb
  import simple_if_pkg::*;
#(
  parameter type apb_req_t      = base_pkg::apb_req_t,
  parameter type apb_resp_t     = base_pkg::apb_resp_t,
  parameter int  ADDR_W         = base_pkg::APB_ADDR_W,
  parameter int  DATA_W         = base_pkg::APB_DATA_W,
  parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output apb_req_t            apb_req_o,
  input  apb_resp_t           apb_resp_i
);

  if ((TIMEOUT_CYCLES < 1) || (DATA_W % 8 != 0)) begin : g_bad_params
  end

  simple_if_to_apb_state_e state_q;

  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                psel_q;
  logic                penable_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                timeout_hit;

`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .clear_i   (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !apb_resp_i.pready),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            // Read data/strobe are zeroed at capture so the bus sees 0 for reads.
            addr_q      <= req_addr_i;
            we_q        <= req_we_i;
            wdata_q     <= req_we_i ? req_wdata_i : '0;
            wstrb_q     <= req_we_i ? req_wstrb_i : '0;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb_resp_i.pready) begin
            rsp_rdata_q <= we_q ? '0 : apb_resp_i.prdata;
            rsp_err_q   <= apb_resp_i.pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    apb_req_o         = '0;
    apb_req_o.paddr   = addr_q;
    apb_req_o.psel    = psel_q;
    apb_req_o.penable = penable_q;
    apb_req_o.pwrite  = we_q;
    apb_req_o.pwdata  = wdata_q;
    apb_req_o.pstrb   = wstrb_q;
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_simple_if_to_apb.sv
// tb/tb_simple_if_to_apb.sv - directed self-checking bench for simple_if_to_apb
module tb_simple_if_to_apb;

  logic               clk;
  logic               arst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wstrb;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  base_pkg::apb_req_t  apb_req;
  base_pkg::apb_resp_t apb_resp;

  int errors = 0;
  int checks = 0;

  simple_if_to_apb #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .apb_req_o   (apb_req),
    .apb_resp_i  (apb_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for a single edge; returns at the negedge of the SETUP cycle.
  task automatic handshake(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL hs_ready: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_wstrb = 4'h5;
  endtask

  task automatic write_zero_wait(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb);
    handshake(1'b1, addr, wdata, wstrb);
    checks++;
    if ({apb_req.psel, apb_req.penable, apb_req.pwrite} !== 3'b101 || apb_req.paddr !== addr ||
        apb_req.pwdata !== wdata || apb_req.pstrb !== wstrb) begin
      errors++; $display("FAIL wr_setup: got sel/en/wr=%b%b%b addr=%h data=%h strb=%h expected 101 %h %h %h",
        apb_req.psel, apb_req.penable, apb_req.pwrite, apb_req.paddr, apb_req.pwdata, apb_req.pstrb,
        addr, wdata, wstrb);
    end
    @(negedge clk);
    apb_resp.pready = 1'b1;
    checks++;
    if ({apb_req.psel, apb_req.penable, apb_req.pwrite} !== 3'b111 || apb_req.paddr !== addr ||
        apb_req.pwdata !== wdata || apb_req.pstrb !== wstrb || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_access: got sel/en/wr=%b%b%b addr=%h data=%h strb=%h rsp_valid=%b",
        apb_req.psel, apb_req.penable, apb_req.pwrite, apb_req.paddr, apb_req.pwdata, apb_req.pstrb, rsp_valid);
    end
    @(negedge clk);
    apb_resp.pready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || apb_req.psel !== 1'b0) begin
      errors++; $display("FAIL wr_resp: got valid=%b err=%b rdata=%h psel=%b expected 1 0 0 0",
        rsp_valid, rsp_err, rsp_rdata, apb_req.psel);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || apb_req.psel !== 1'b0) begin
      errors++; $display("FAIL wr_idle: got valid=%b ready=%b psel=%b expected 0 1 0",
        rsp_valid, req_ready, apb_req.psel);
    end
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (apb_req !== '0) begin
      errors++; $display("FAIL reset_apb: got %h expected 0", apb_req);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
        req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_write_zero_wait;
    write_zero_wait(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
  endtask

  task automatic test_read_wait;
    handshake(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if ({apb_req.psel, apb_req.penable, apb_req.pwrite} !== 3'b100 || apb_req.paddr !== 32'h20 ||
        apb_req.pstrb !== 4'h0 || apb_req.pwdata !== 32'h0) begin
      errors++; $display("FAIL rd_setup: got sel/en/wr=%b%b%b addr=%h strb=%h wdata=%h",
        apb_req.psel, apb_req.penable, apb_req.pwrite, apb_req.paddr, apb_req.pstrb, apb_req.pwdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        apb_resp.pready = 1'b1;
        apb_resp.prdata = 32'h1234_5678;
      end
      checks++;
      if ({apb_req.psel, apb_req.penable} !== 2'b11 || apb_req.pstrb !== 4'h0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rd_wait%0d: got sel/en=%b%b strb=%h valid=%b expected 11 0 0",
          i, apb_req.psel, apb_req.penable, apb_req.pstrb, rsp_valid);
      end
    end
    @(negedge clk);
    apb_resp.pready = 1'b0;
    apb_resp.prdata = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rd_resp: got valid=%b rdata=%h err=%b expected 1 12345678 0",
        rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_slave_error;
    handshake(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    @(negedge clk);
    apb_resp.pready  = 1'b1;
    apb_resp.pslverr = 1'b1;
    apb_resp.prdata  = 32'hAAAA_5555;
    @(negedge clk);
    apb_resp.pready  = 1'b0;
    apb_resp.pslverr = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'hAAAA_5555) begin
      errors++; $display("FAIL slverr_resp: got valid=%b err=%b rdata=%h expected 1 1 aaaa5555",
        rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    apb_resp.pslverr = 1'b0;
    write_zero_wait(32'h0000_0044, 32'h0102_0304, 4'h3);
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    handshake(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    @(negedge clk);
    apb_resp.pready = 1'b1;
    apb_resp.prdata = 32'hCAFE_0001;
    @(negedge clk);
    apb_resp.pready = 1'b0;
    apb_resp.prdata = 32'h0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0099; req_wdata = 32'h1; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || rsp_err !== 1'b0 ||
          req_ready !== 1'b0 || apb_req.psel !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b ready=%b psel=%b expected 1 cafe0001 0 0 0",
          i, rsp_valid, rsp_rdata, rsp_err, req_ready, apb_req.psel);
      end
      if (i < 4) @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || apb_req.psel !== 1'b0) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b psel=%b expected 0 1 0",
        rsp_valid, req_ready, apb_req.psel);
    end
    @(negedge clk);
    checks++;
    if (apb_req.psel !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ignored_req: got psel=%b ready=%b expected 0 1", apb_req.psel, req_ready);
    end
  endtask

  task automatic test_reset_mid_access;
    handshake(1'b1, 32'h0000_0060, 32'h7777_8888, 4'hC);
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    checks++;
    if (apb_req.psel !== 1'b0 || apb_req.penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid: got psel=%b pen=%b valid=%b ready=%b expected 0 0 0 1",
        apb_req.psel, apb_req.penable, rsp_valid, req_ready);
    end
    apb_resp.pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || apb_req.psel !== 1'b0) begin
        errors++; $display("FAIL rst_no_rsp%0d: got valid=%b psel=%b expected 0 0", i, rsp_valid, apb_req.psel);
      end
    end
    apb_resp.pready = 1'b0;
    write_zero_wait(32'h0000_0064, 32'h0BAD_F00D, 4'h0);
  endtask

  task automatic test_timeout;
    handshake(1'b0, 32'h0000_0070, 32'h0, 4'h0);
`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
    apb_resp.prdata = 32'hFFFF_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({apb_req.psel, apb_req.penable} !== 2'b11 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL to_access%0d: got sel/en=%b%b valid=%b expected 11 0",
          i, apb_req.psel, apb_req.penable, rsp_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || apb_req.psel !== 1'b0) begin
      errors++; $display("FAIL to_abort: got valid=%b err=%b rdata=%h psel=%b expected 1 1 0 0",
        rsp_valid, rsp_err, rsp_rdata, apb_req.psel);
    end
    apb_resp.prdata = 32'h0;
    @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    checks++;
    if ({apb_req.psel, apb_req.penable} !== 2'b11 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL to_disabled: got sel/en=%b%b valid=%b expected 11 0",
        apb_req.psel, apb_req.penable, rsp_valid);
    end
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  initial begin
    arst_n    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b1;
    apb_resp  = '0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_backpressure();
    test_reset_mid_access();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simple_if_to_apb.md
Name: simple_if_to_apb

Overview:
- APB initiator (master) bridge: accepts single-beat read/write requests on a simple valid/ready memory-style interface and executes each as one APB4 transfer.
- Returns read data and error status on a valid/ready response channel.
- Placed where on-chip logic (DMA, test sequencer, CPU-side simple port) must reach APB peripherals and APB-fronted memories.
- It is the counterpart of the APB-slave-to-simple-interface bridge.

Parameters:
- apb_req_t, base_pkg::apb_req_t, APB request struct (paddr, psel, penable, pwrite, pwdata, pstrb).
- apb_resp_t, base_pkg::apb_resp_t, APB response struct (prdata, pready, pslverr).
- ADDR_W, $bits(apb_req_t.paddr), request address width.
- DATA_W, $bits(apb_req_t.pwdata), data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit. Used only with the optional feature; must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  reset, synchronous, active-low, sampled on the rising edge of clk_i.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  DATA_W/8  write byte strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes.
- rsp_err_o  out  1  PSLVERR or timeout.
- apb_req_o  out  apb_req_t  APB request.
- apb_resp_i  in  apb_resp_t  APB response.

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-low, on arst_ni; clock is clk_i.
- Reset values: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, req_ready_o=1 after release, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- Reset mid-operation: takes effect at the next clock edge.
  - psel and penable drop immediately.
  - Any in-flight transfer and any pending response are discarded; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On handshake, capture addr, we, wdata and wstrb into holding registers; go to SETUP.
- SETUP:
  - Exactly one cycle with psel=1, penable=0; paddr, pwrite, pwdata and pstrb are driven from the holding registers.
  - Go to ACCESS.
- ACCESS:
  - psel=1, penable=1; all APB request fields are held stable.
  - Stay while pready=0.
  - On pready=1: capture prdata (read) or 0 (write) into rsp_rdata_o, capture pslverr into rsp_err_o, drop psel and penable, go to RESP.
- RESP:
  - rsp_valid_o=1; data and error are held stable until rsp_ready_i=1.
  - Then go to IDLE with rsp_valid_o=0 on the next cycle.
- req_ready_o is high only in IDLE. One transfer is outstanding at most; there is no pipelining.
- Latency: handshake at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2. With pready=1 in the first ACCESS cycle, rsp_valid_o is high in cycle N+3. Each extra pready=0 cycle adds one cycle.
- Minimum throughput: 4 cycles per transfer with rsp_ready_i held high.
- Reads: pstrb=0 and pwdata=0.
- Writes: pstrb=req_wstrb_i as captured. A wstrb of 0 is still issued as an APB write.
- paddr is the captured req_addr_i, unmodified; no alignment or range check is done.
- Request inputs that change while req_ready_o=0 are ignored.
- pready and pslverr are ignored outside ACCESS.
- No back-to-back psel: psel is always low for at least one cycle between transfers (the RESP and IDLE cycles).

Optional Feature:
- Macro: SIMPLE_IF_TO_APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments for each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts: psel and penable drop, go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - A pready=1 arriving in the same cycle as the limit is reached wins, giving a normal completion.
- Undefined: ACCESS waits indefinitely for pready; no counter logic exists.

Decomposition:
- Shared package simple_if_pkg holds:
  - state enum simple_if_to_apb_state_e {IDLE, SETUP, ACCESS, RESP};
  - the default TIMEOUT_CYCLES constant;
  - typedef simple_if_rsp_t {rdata, err}.
- APB struct types are taken from base_pkg and apb/typedef.svh.
- Natural sub-module: apb_timeout_cnt (clear, enable, expired output). It is instantiated only under SIMPLE_IF_TO_APB_TIMEOUT_EN.

Test Plan:
- Write, zero wait:
  - Stimulus: req addr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF; slave pready=1 in the first ACCESS cycle.
  - Response: SETUP then ACCESS with stable fields; rsp_valid_o at N+3 with err=0, rdata=0.
- Read with 3 wait states:
  - Stimulus: addr=0x20; slave returns prdata=0x1234_5678 after 3 pready=0 cycles.
  - Response: rsp_valid_o at N+6 with rdata=0x1234_5678; pstrb=0 throughout.
- Slave error: read with pslverr=1, pready=1 → rsp_err_o=1; the next request is accepted normally after the response.
- Response backpressure:
  - Stimulus: rsp_ready_i held low for 5 cycles.
  - Response: rsp_valid_o, data and err stay stable; req_ready_o=0; no psel until rsp_ready_i=1 and the block is back in IDLE.
- Reset mid-ACCESS: arst_ni=0 for 1 cycle during ACCESS → psel and penable are 0 after the edge, no response is produced, and a fresh write completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): pready held 0 → abort after 8 ACCESS cycles with rsp_err_o=1 and rdata=0; with the macro undefined, the block is still in ACCESS after 1000 cycles.
